limn2600_memctl: RTL and testbench
==================================

# limn2600_memctl

Single-port memory controller sitting directly upstream of the Limn2600 128K SRAM. Arbitrates between the instruction-fetch port and the load/store port and issues one-cycle chip-select strobes to the SRAM. Sub-word stores become read-modify-write sequences, because the SRAM has no byte enables. Returns read data with a one-cycle acknowledge, and reports a bus error if the SRAM never raises `rdy`.

## Interface
- `TIMEOUT`, 16: cycles the controller waits in a WAIT state for `mem_rdy` before reporting an error (≥2).
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request, level; held with `i_addr` stable until `i_ack`.
- `i_addr` in 32: fetch byte address; bits [1:0] ignored.
- `i_ack` out 1: one-cycle pulse; fetch complete.
- `i_rdata` out 32: fetch data; valid while `i_ack`=1.
- `i_err` out 1: valid with `i_ack`; timeout occurred.
- `d_req` in 1: data request, level; `d_we`/`d_be`/`d_addr`/`d_wdata` stable until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: store byte enables; lane k = bits [8k+7:8k]; ignored on loads.
- `d_addr` in 32: data byte address; bits [1:0] ignored.
- `d_wdata` in 32: store data.
- `d_ack` out 1: one-cycle pulse; data access complete.
- `d_rdata` out 32: load data; valid while `d_ack`=1.
- `d_err` out 1: valid with `d_ack`; timeout occurred.
- `mem_cs` out 1: SRAM chip select; never high two consecutive cycles.
- `mem_we` out 1: SRAM write enable; meaningful only with `mem_cs`.
- `mem_addr` out 32: SRAM address, {addr[31:2], 2'b00}.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdy` in 1: SRAM ready; rises the cycle after a `mem_cs` cycle.
- `mem_rdata` in 32: SRAM read data; valid when `mem_rdy`=1.

## Operation
- **States:** IDLE, ISSUE, WAIT, WR_ISSUE, WR_WAIT, RESP.
- **Arbitration in IDLE:**
  - With one requester, grant it.
  - With both requesting, grant the one not granted last.
  - After reset, the data port wins the first tie.
  - On grant, latch the address, `we`, `be`, `wdata` and the owner, and record the owner as last-granted.
- **Op classification (data port):**
  - Load: read.
  - Store with `be`=4'b1111: full write.
  - Store with `be`=4'b0000: null. IDLE→RESP with no SRAM access, `err`=0.
  - Any other `be`: partial write.
- **Fetch ops:** always read.
- **ISSUE:**
  - `mem_cs`=1 for exactly this cycle.
  - `mem_we`=1 only for a full write; `mem_wdata`=latched wdata.
  - Next state WAIT.
- **WAIT:**
  - `mem_cs`=0.
  - On `mem_rdy`=1, a read captures `mem_rdata` into the response register and goes to RESP.
  - On `mem_rdy`=1, a full write goes to RESP.
  - On `mem_rdy`=1, a partial write forms merged[k] = be[k] ? wdata[k] : mem_rdata[k] and goes to WR_ISSUE.
- **WR_ISSUE:** `mem_cs`=1, `mem_we`=1, `mem_wdata`=merged; next state WR_WAIT.
- **WR_WAIT:** on `mem_rdy`=1, go to RESP.
- **Timeout:**
  - A counter clears on entry to WAIT or WR_WAIT and increments each cycle `mem_rdy`=0.
  - When it reaches `TIMEOUT`, go to RESP with `err`=1.
  - `rdata`=0 for reads; a partial write is abandoned without its write phase.
- **RESP:**
  - Owner's `ack`=1; the other port's `ack`=0.
  - `rdata` comes from the response register; stores return 0.
  - Next state IDLE.
  - The requester may hold `req` high for a new request; it is sampled in the following IDLE cycle.
- **Reset:** a synchronous reset in any state forces IDLE. No ack is issued and no further `mem_cs` occurs. An in-flight partial write may be lost.

## Timing
- **Reset values:** every output is 0, including `mem_addr`, `mem_wdata`, `i_rdata` and `d_rdata`.
- **Latency** (cycle 0 = IDLE cycle with `req` sampled, SRAM answering 1 cycle after cs):
  - Read or full write: ISSUE c1, WAIT c2, ack c3.
  - Partial write: ISSUE c1, WAIT c2, WR_ISSUE c3, WR_WAIT c4, ack c5.
  - Null store: ack c1.
- **Throughput:** minimum 4 cycles per read, because IDLE is always visited between requests.
- **Stale ready:** `mem_rdy` is ignored outside WAIT and WR_WAIT. It has always returned to 0 before the next WAIT, since cs is low in IDLE.
- **Data paths:** `ack`, `err` and `rdata` are registered. No combinational path from `req` to `mem_*`.

## Test plan
- **Read:** preload SRAM word 0x10 = 0xDEADBEEF; fetch `i_addr`=0x00000042 → `mem_addr`=0x00000040 strobed one cycle; `i_ack` 3 cycles after req with `i_rdata`=0xDEADBEEF, `i_err`=0.
- **Contention:** `i_req` and `d_req` rise in the same cycle after reset → data served first, fetch next, then alternating while both are held. Exactly one `mem_cs` pulse per read.
- **Partial store:** word at 0x00000100 = 0x11223344; store `be`=4'b0101, wdata 0xAABBCCDD → SRAM holds 0x11BB33DD; `d_ack` at c5; two cs pulses, second with `mem_we`=1.
- **Full and null stores:**
  - `be`=4'b1111 → one cs pulse with `mem_we`=1, ack at c3.
  - `be`=4'b0000 → no cs, ack at c1, memory unchanged.
- **Timeout:** tie `mem_rdy` to 0, TIMEOUT=16 → ack with `err`=1 and `rdata`=0. Only one cs pulse, even for a partial store.
- **Reset mid-op:** assert `rst` during WAIT → next cycle all outputs 0 and no ack. A new request afterwards completes normally.

Source files
------------

// File: rtl/limn2600_memctl_if.sv
// Bus bundle for the Limn2600 memory controller: fetch port, load/store port and SRAM side.
// The slave modport is the controller's view; master is the surrounding system's view.
interface limn2600_memctl_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdy, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdy, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/limn2600_memctl.sv
// Single-port SRAM controller: arbitrates fetch vs load/store, turns sub-word stores into
// read-modify-write, and reports a bus error when the SRAM never answers.
module limn2600_memctl #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    limn2600_memctl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_READ, OP_FULL, OP_PART} op_t;

    state_t         state_reg, state_next;
    op_t            op_reg;
    logic           owner_reg;      // 1 = data port owns the current access
    logic           last_reg;       // 1 = data port was granted last
    logic [31:2]    addr_reg;
    logic [3:0]     be_reg;
    logic [31:0]    wdata_reg;      // store data, replaced by the merged word for partial writes
    logic [31:0]    resp_reg;
    logic           err_reg;
    logic [CW-1:0]  cnt_reg;

    logic           grant_d, grant_i, null_store, timed_out, resp;
    logic [31:0]    merged;
    logic           unused_bits;

    assign unused_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    // On a tie the port that was not served last wins.
    assign grant_d    = bus.d_req && (!bus.i_req || !last_reg);
    assign grant_i    = bus.i_req && !grant_d;
    assign null_store = grant_d && bus.d_we && (bus.d_be == 4'b0000);
    assign timed_out  = !bus.mem_rdy && (cnt_reg == CW'(TIMEOUT - 1));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (null_store)              state_next = RESP;
                else if (grant_d || grant_i) state_next = ISSUE;
            end
            ISSUE:    state_next = WAIT;
            WAIT: begin
                if (bus.mem_rdy)    state_next = (op_reg == OP_PART) ? WR_ISSUE : RESP;
                else if (timed_out) state_next = RESP;
            end
            WR_ISSUE: state_next = WR_WAIT;
            WR_WAIT:  if (bus.mem_rdy || timed_out) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg    <= OP_READ;
            owner_reg <= 1'b0;
            last_reg  <= 1'b0;
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            resp_reg  <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        owner_reg <= grant_d;
                        last_reg  <= grant_d;
                        addr_reg  <= grant_d ? bus.d_addr[31:2] : bus.i_addr[31:2];
                        be_reg    <= grant_d ? bus.d_be : 4'b0000;
                        wdata_reg <= grant_d ? bus.d_wdata : 32'h0;
                        resp_reg  <= '0;
                        err_reg   <= 1'b0;
                        if (!grant_d || !bus.d_we)   op_reg <= OP_READ;
                        else if (bus.d_be == 4'hF)   op_reg <= OP_FULL;
                        else                         op_reg <= OP_PART;
                    end
                end
                ISSUE, WR_ISSUE: cnt_reg <= '0;
                WAIT: begin
                    if (bus.mem_rdy) begin
                        if (op_reg == OP_READ) resp_reg  <= bus.mem_rdata;
                        if (op_reg == OP_PART) wdata_reg <= merged;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (timed_out) err_reg <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (!bus.mem_rdy) begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (timed_out) err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        resp          = (state_reg == RESP);
        bus.mem_cs    = (state_reg == ISSUE) || (state_reg == WR_ISSUE);
        bus.mem_we    = ((state_reg == ISSUE) && (op_reg == OP_FULL)) || (state_reg == WR_ISSUE);
        bus.mem_addr  = {addr_reg, 2'b00};
        bus.mem_wdata = wdata_reg;
        bus.i_ack     = resp && !owner_reg;
        bus.d_ack     = resp && owner_reg;
        bus.i_rdata   = (resp && !owner_reg) ? resp_reg : 32'h0;
        bus.d_rdata   = (resp && owner_reg) ? resp_reg : 32'h0;
        bus.i_err     = resp && !owner_reg && err_reg;
        bus.d_err     = resp && owner_reg && err_reg;
    end
endmodule

// File: tb/tb_limn2600_memctl.sv
// Randomised scoreboard bench for limn2600_memctl with an SRAM model and a word-level reference memory.
module tb_limn2600_memctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    limn2600_memctl_if bus();
    limn2600_memctl #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sram    [0:255];
    logic [31:0] ref_mem [0:255];
    logic [32:0] i_q[$];
    logic [32:0] d_q[$];
    string       order_s = "";
    int          cs_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_cs_addr = 32'h0;
    bit          sram_dead = 1'b0;

    // SRAM: a cs seen in one cycle produces rdy (and read data) in the next cycle.
    initial begin
        logic        pend, pwe, prev_cs;
        logic [31:0] pa, pd;
        bus.mem_rdy   = 1'b0;
        bus.mem_rdata = 32'h0;
        prev_cs       = 1'b0;
        #1;
        for (int w = 0; w < 256; w++) sram[w] = ref_mem[w];
        forever begin
            @(negedge clk);
            pend = bus.mem_cs; pwe = bus.mem_we; pa = bus.mem_addr; pd = bus.mem_wdata;
            if (pend) begin
                tests++;
                if (prev_cs) begin
                    fails++;
                    $display("FAIL cs_back_to_back: mem_cs high in consecutive cycles at %0t, required single-cycle strobe", $time);
                end
                cs_cnt++;
                if (pwe) we_cnt++;
                last_cs_addr = pa;
            end
            prev_cs = pend;
            @(posedge clk); #1;
            bus.mem_rdy   = pend && !sram_dead;
            bus.mem_rdata = $urandom;
            if (pend) begin
                if (pwe) sram[pa[9:2]] = pd;
                else     bus.mem_rdata = sram[pa[9:2]];
            end
        end
    end

    // Monitor: pop one expectation per acknowledge.
    always @(negedge clk) begin
        logic [32:0] exp;
        if (bus.i_ack && bus.d_ack) begin
            tests++; fails++;
            $display("FAIL dual_ack: both acks high at %0t, required at most one", $time);
        end
        if (bus.i_ack) begin
            tests++;
            order_s = {order_s, "I"};
            if (i_q.size() == 0) begin
                fails++;
                $display("FAIL i_unexpected_ack: got ack err=%0b rdata=%h, required no ack", bus.i_err, bus.i_rdata);
            end else begin
                exp = i_q.pop_front();
                if ({bus.i_err, bus.i_rdata} !== exp) begin
                    fails++;
                    $display("FAIL i_resp: got err=%0b rdata=%h, required err=%0b rdata=%h", bus.i_err, bus.i_rdata, exp[32], exp[31:0]);
                end
            end
        end
        if (bus.d_ack) begin
            tests++;
            order_s = {order_s, "D"};
            if (d_q.size() == 0) begin
                fails++;
                $display("FAIL d_unexpected_ack: got ack err=%0b rdata=%h, required no ack", bus.d_err, bus.d_rdata);
            end else begin
                exp = d_q.pop_front();
                if ({bus.d_err, bus.d_rdata} !== exp) begin
                    fails++;
                    $display("FAIL d_resp: got err=%0b rdata=%h, required err=%0b rdata=%h", bus.d_err, bus.d_rdata, exp[32], exp[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end else begin
            $display("[TB] %s ok (%0h)", name, got);
        end
    endtask

    function automatic logic [133:0] outs();
        return {bus.i_ack, bus.i_rdata, bus.i_err, bus.d_ack, bus.d_rdata, bus.d_err,
                bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic check_zero(input string name);
        logic [133:0] v;
        v = outs();
        tests++;
        if (v !== '0) begin
            fails++;
            $display("FAIL %s: got outputs %h, required all zero", name, v);
        end else begin
            $display("[TB] %s ok", name);
        end
    endtask

    // Reference behaviour of one data-port access; updates the reference memory for stores.
    function automatic logic [32:0] model_data(input logic we, input logic [3:0] be,
                                               input logic [31:0] a, input logic [31:0] wd);
        int w;
        w = int'(a[9:2]);
        if (we && be == 4'b0000) return {1'b0, 32'h0};
        if (sram_dead)           return {1'b1, 32'h0};
        if (!we)                 return {1'b0, ref_mem[w]};
        for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[w][8*k +: 8] = wd[8*k +: 8];
        return {1'b0, 32'h0};
    endfunction

    task automatic wait_ack(input bit dport, output int lat);
        bit done;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (dport ? bus.d_ack : bus.i_ack) done = 1'b1;
            else begin
                lat++;
                if (lat > 200) begin
                    tests++; fails++;
                    $display("FAIL %s_ack_timeout: no ack after %0d cycles, required ack", dport ? "d" : "i", lat);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat);
        i_q.push_back(sram_dead ? {1'b1, 32'h0} : {1'b0, ref_mem[a[9:2]]});
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        wait_ack(1'b0, lat);
        bus.i_req  = 1'b0;
        $display("[TB] fetch addr=%h lat=%0d", a, lat);
    endtask

    task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] wd, output int lat);
        d_q.push_back(model_data(we, be, a, wd));
        bus.d_we    = we;
        bus.d_be    = be;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        wait_ack(1'b1, lat);
        bus.d_req   = 1'b0;
        $display("[TB] data we=%0b be=%b addr=%h wdata=%h lat=%0d", we, be, a, wd, lat);
    endtask

    initial begin
        int          lat, c0, w0;
        logic [31:0] v;
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        for (int w = 0; w < 256; w++) ref_mem[w] = $urandom;
        ref_mem[16] = 32'hDEADBEEF;
        ref_mem[64] = 32'h11223344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight after reset: data first, then alternating.
        c0 = cs_cnt;
        order_s = "";
        fork
            begin
                int ld1, ld2;
                do_data(1'b0, 4'h0, 32'h0000_0140, 32'h0, ld1);
                do_data(1'b0, 4'h0, 32'h0000_0144, 32'h0, ld2);
                check("cont_d1_lat", 64'(ld1), 64'd3);
                check("cont_d2_lat", 64'(ld2), 64'd7);
            end
            begin
                int lf1, lf2;
                do_fetch(32'h0000_0000, lf1);
                do_fetch(32'h0000_0004, lf2);
                check("cont_i1_lat", 64'(lf1), 64'd7);
                check("cont_i2_lat", 64'(lf2), 64'd7);
            end
        join
        tests++;
        if (order_s != "DIDI") begin
            fails++;
            $display("FAIL cont_order: got %s, required DIDI", order_s);
        end
        check("cont_cs_pulses", 64'(cs_cnt - c0), 64'd4);

        // Read with unaligned byte address.
        c0 = cs_cnt;
        do_fetch(32'h0000_0042, lat);
        check("read_lat", 64'(lat), 64'd3);
        check("read_cs_pulses", 64'(cs_cnt - c0), 64'd1);
        check("read_mem_addr", 64'(last_cs_addr), 64'h40);

        // Partial store becomes read-modify-write.
        c0 = cs_cnt; w0 = we_cnt;
        do_data(1'b1, 4'b0101, 32'h0000_0100, 32'hAABBCCDD, lat);
        check("part_lat", 64'(lat), 64'd5);
        check("part_cs_pulses", 64'(cs_cnt - c0), 64'd2);
        check("part_we_pulses", 64'(we_cnt - w0), 64'd1);
        check("part_sram_word", 64'(sram[64]), 64'h11BB33DD);
        do_data(1'b0, 4'h0, 32'h0000_0100, 32'h0, lat);

        // Full and null stores.
        c0 = cs_cnt; w0 = we_cnt;
        do_data(1'b1, 4'hF, 32'h0000_0104, 32'hCAFEF00D, lat);
        check("full_lat", 64'(lat), 64'd3);
        check("full_cs_pulses", 64'(cs_cnt - c0), 64'd1);
        check("full_we_pulses", 64'(we_cnt - w0), 64'd1);
        check("full_sram_word", 64'(sram[65]), 64'hCAFEF00D);
        c0 = cs_cnt;
        v  = sram[66];
        do_data(1'b1, 4'h0, 32'h0000_0108, 32'h12345678, lat);
        check("null_lat", 64'(lat), 64'd1);
        check("null_cs_pulses", 64'(cs_cnt - c0), 64'd0);
        check("null_sram_word", 64'(sram[66]), 64'(v));

        // Dead SRAM: one strobe, then an error response.
        sram_dead = 1'b1;
        c0 = cs_cnt;
        do_fetch(32'h0000_0008, lat);
        check("to_fetch_cs_pulses", 64'(cs_cnt - c0), 64'd1);
        check("to_fetch_lat_range", 64'(lat >= 17 && lat <= 20), 64'd1);
        c0 = cs_cnt; w0 = we_cnt;
        v  = sram[67];
        do_data(1'b1, 4'b0011, 32'h0000_010C, 32'h55667788, lat);
        check("to_part_cs_pulses", 64'(cs_cnt - c0), 64'd1);
        check("to_part_we_pulses", 64'(we_cnt - w0), 64'd0);
        check("to_part_sram_word", 64'(sram[67]), 64'(v));
        sram_dead = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset while in WAIT: everything returns to zero, no acknowledge.
        bus.i_addr = 32'h0000_000C;
        bus.i_req  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midop_reset_outputs");
        @(posedge clk); #1;
        do_fetch(32'h0000_000C, lat);
        check("post_reset_lat", 64'(lat), 64'd3);

        // Random traffic on both ports.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int g, lr;
                    logic [31:0] a;
                    g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge clk); #1; end
                    a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
                    do_fetch(a, lr);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    int g, lr;
                    logic [31:0] a;
                    g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge clk); #1; end
                    a = (32'($urandom_range(64, 127)) << 2) | 32'($urandom_range(0, 3));
                    do_data(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, lr);
                end
            end
        join

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 64'(i_q.size() + d_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
